// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Byte handshake: a byte moves on a rising clk edge exactly when byte_valid and byte_ready are both 1; the source holds byte_data stable until then.
interface imem_program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_write,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory as 32-bit words,
// holding the core in reset until the whole program has been written.
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    imem_program_loader_if.master       bus,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        error,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t            state;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;

    logic        xfer;
    logic [15:0] hdr_n;
    logic        hdr_bad;
    logic [16:0] next_idx;
    logic        last_word;

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign hdr_n     = {count[15:8], bus.byte_data};
    assign hdr_bad   = (hdr_n == 16'd0) || ({16'd0, hdr_n} > 32'(MAX_WORDS));
    assign next_idx  = 17'(word_idx) + 17'd1;
    assign last_word = (next_idx == {1'b0, count});
    assign dbg_state = state;

    // byte_ready is registered, so it is updated together with every state change
    // and always equals "state is HDR_HI, HDR_LO or DATA".
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= 16'd0;
            word_idx       <= '0;
            byte_idx       <= 2'd0;
            shift          <= 24'd0;
            bus.byte_ready <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= 32'd0;
            bus.mem_wdata  <= 32'd0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.mem_write <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state          <= HDR_HI;
                        bus.byte_ready <= 1'b1;
                        cpu_hold       <= 1'b1;
                        done           <= 1'b0;
                        error          <= 1'b0;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= bus.byte_data;
                        state       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= bus.byte_data;
                        if (hdr_bad) begin
                            state          <= ERR;
                            error          <= 1'b1;
                            bus.byte_ready <= 1'b0;
                        end else begin
                            state    <= DATA;
                            word_idx <= '0;
                            byte_idx <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shift    <= {shift[15:0], bus.byte_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state          <= WRITE;
                            bus.byte_ready <= 1'b0;
                            bus.mem_write  <= 1'b1;
                            bus.mem_addr   <= 32'(word_idx);
                            bus.mem_wdata  <= {shift, bus.byte_data};
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_idx <= 2'd0;
                    if (last_word) begin
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state          <= DATA;
                        bus.byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.byte_ready <= 1'b0;
                    cpu_hold       <= 1'b1;
                    done           <= 1'b0;
                    error          <= 1'b0;
                end
            endcase
        end
    end

endmodule
